// File: rtl/ledmat_pkg.sv
// Shared constants, scan state type and helpers for the LED matrix output path.
package ledmat_pkg;

    localparam int unsigned COLS       = 64;
    localparam int unsigned SCAN_ROWS  = 16;
    localparam int unsigned BIT_PLANES = 8;
    localparam int unsigned PIXEL_W    = 3 * BIT_PLANES;
    localparam int unsigned PLANE_W    = $clog2(BIT_PLANES);

    // Colour field positions inside one pixel word.
    localparam int unsigned R_MSB = 23;
    localparam int unsigned G_MSB = 15;
    localparam int unsigned B_MSB = 7;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH,
        DISPLAY
    } scan_state_e;

    // Two address-issue cycles followed by the read pipeline.
    function automatic int unsigned slot_cycles(input int unsigned rd_latency);
        return 2 + rd_latency;
    endfunction

    // Returns {R,G,B} bit 'plane' of one pixel.
    function automatic logic [2:0] rgb_bits(input logic [PIXEL_W-1:0] pix,
                                            input logic [PLANE_W-1:0] plane);
        logic [BIT_PLANES-1:0] r;
        logic [BIT_PLANES-1:0] g;
        logic [BIT_PLANES-1:0] b;
        r = pix[R_MSB -: BIT_PLANES];
        g = pix[G_MSB -: BIT_PLANES];
        b = pix[B_MSB -: BIT_PLANES];
        return {r[plane], g[plane], b[plane]};
    endfunction

endpackage

// File: rtl/bcm_oe_timer.sv
// Output-enable pulse generator: drives OE low for OE_BASE<<plane cycles after start.
module bcm_oe_timer #(
    parameter int unsigned OE_BASE    = 1,
    parameter int unsigned BIT_PLANES = 8,
    parameter int unsigned PLANE_W    = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [PLANE_W-1:0] i_plane,
    output logic               o_oe_n,
    output logic               o_done
);

    localparam int unsigned MAX_LEN = OE_BASE << (BIT_PLANES - 1);
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_oe_n;
    logic             r_done;
    logic [CNT_W-1:0] w_len;

    assign w_len  = CNT_W'(OE_BASE << i_plane);
    assign o_oe_n = r_oe_n;
    assign o_done = r_done;

    // Count down the display window; r_done marks its final low cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_oe_n <= 1'b1;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_cnt  <= w_len - CNT_W'(1);
            r_oe_n <= 1'b0;
            r_done <= (w_len == CNT_W'(1));
        end else if (!r_oe_n) begin
            if (r_cnt == '0) begin
                r_oe_n <= 1'b1;
                r_done <= 1'b0;
            end else begin
                r_cnt  <= r_cnt - CNT_W'(1);
                r_done <= (r_cnt == CNT_W'(1));
            end
        end
    end

endmodule

// File: rtl/outbuf_scan_reader.sv
// Read-side scan engine: fetches upper/lower pixels per column and drives HUB75 segments
// with 1/16 scan and BCM brightness.
module outbuf_scan_reader #(
    parameter int unsigned DATA_WIDTH       = 24,
    parameter int unsigned ADDR_WIDTH       = 11,
    parameter int unsigned NUMBER_OF_BLOCKS = 3,
    parameter int unsigned COLS             = ledmat_pkg::COLS,
    parameter int unsigned SCAN_ROWS        = ledmat_pkg::SCAN_ROWS,
    parameter int unsigned BIT_PLANES       = ledmat_pkg::BIT_PLANES,
    parameter int unsigned RD_LATENCY       = 2,
    parameter int unsigned OE_BASE          = 1
) (
    input  logic                                   i_out_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_ena,
    output logic [ADDR_WIDTH-1:0]                  o_outbuf_out_addr,
    input  logic [DATA_WIDTH*NUMBER_OF_BLOCKS-1:0] i_outbuf_out_data,
    output logic [6*NUMBER_OF_BLOCKS-1:0]          o_panel_rgb,
    output logic                                   o_panel_clk,
    output logic                                   o_panel_lat,
    output logic                                   o_panel_oe_n,
    output logic [$clog2(SCAN_ROWS)-1:0]           o_panel_row,
    output logic                                   o_frame_done
);

    import ledmat_pkg::*;

    localparam int unsigned SLOT    = slot_cycles(RD_LATENCY);
    localparam int unsigned CYC_W   = $clog2(SLOT);
    localparam int unsigned COL_W   = $clog2(COLS + 1);
    localparam int unsigned ROW_W   = $clog2(SCAN_ROWS);
    localparam int unsigned PLN_W   = $clog2(BIT_PLANES);

    localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(SLOT - 1);
    localparam logic [CYC_W-1:0] CYC_UPPER  = CYC_W'(RD_LATENCY);
    localparam logic [CYC_W-1:0] CYC_PCLK   = CYC_W'(2);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(SCAN_ROWS - 1);
    localparam logic [PLN_W-1:0] PLANE_LAST = PLN_W'(BIT_PLANES - 1);

    scan_state_e r_state;
    scan_state_e w_state_d;
    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] w_col_d;
    logic [CYC_W-1:0] r_cyc;
    logic [CYC_W-1:0] w_cyc_d;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_row_d;
    logic [PLN_W-1:0] r_plane;
    logic [PLN_W-1:0] w_plane_d;

    logic [DATA_WIDTH*NUMBER_OF_BLOCKS-1:0] r_upper;
    logic [6*NUMBER_OF_BLOCKS-1:0]          w_rgb_col;
    logic [ADDR_WIDTH-1:0]                  w_addr_up;
    logic [ADDR_WIDTH-1:0]                  w_addr_lo;

    logic [ADDR_WIDTH-1:0]         r_addr;
    logic [6*NUMBER_OF_BLOCKS-1:0] r_rgb;
    logic                          r_pclk;
    logic                          r_lat;
    logic [ROW_W-1:0]              r_panel_row;

    logic w_oe_start;
    logic w_oe_n;
    logic w_oe_done;

    assign w_oe_start = (r_state == LATCH);

    bcm_oe_timer #(
        .OE_BASE    (OE_BASE),
        .BIT_PLANES (BIT_PLANES),
        .PLANE_W    (PLN_W)
    ) u_oe_timer (
        .i_clk   (i_out_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_oe_start),
        .i_plane (r_plane),
        .o_oe_n  (w_oe_n),
        .o_done  (w_oe_done)
    );

    // Next scan position: slot/cycle walk in SHIFT, plane/row advance after DISPLAY.
    always_comb begin
        w_state_d = r_state;
        w_col_d   = r_col;
        w_cyc_d   = r_cyc;
        w_row_d   = r_row;
        w_plane_d = r_plane;
        case (r_state)
            IDLE: begin
                if (i_ena) begin
                    w_state_d = SHIFT;
                    w_col_d   = '0;
                    w_cyc_d   = '0;
                    w_row_d   = '0;
                    w_plane_d = '0;
                end
            end
            SHIFT: begin
                if (r_cyc == CYC_LAST) begin
                    w_cyc_d = '0;
                    if (r_col == COL_LAST) begin
                        w_state_d = LATCH;
                    end else begin
                        w_col_d = r_col + COL_W'(1);
                    end
                end else begin
                    w_cyc_d = r_cyc + CYC_W'(1);
                end
            end
            LATCH: begin
                w_state_d = DISPLAY;
            end
            DISPLAY: begin
                if (w_oe_done) begin
                    w_col_d   = '0;
                    w_cyc_d   = '0;
                    w_state_d = SHIFT;
                    if (r_plane == PLANE_LAST) begin
                        w_plane_d = '0;
                        if (r_row == ROW_LAST) begin
                            w_row_d = '0;
                            // ENA only matters here, at the frame boundary.
                            w_state_d = i_ena ? SHIFT : IDLE;
                        end else begin
                            w_row_d = r_row + ROW_W'(1);
                        end
                    end else begin
                        w_plane_d = r_plane + PLN_W'(1);
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Read addresses for the slot being entered, and the panel bits of the finished column.
    always_comb begin
        w_addr_up = ADDR_WIDTH'(32'(w_row_d) * COLS + 32'(w_col_d));
        w_addr_lo = ADDR_WIDTH'((32'(w_row_d) + SCAN_ROWS) * COLS + 32'(w_col_d));
        w_rgb_col = '0;
        for (int b = 0; b < NUMBER_OF_BLOCKS; b++) begin
            w_rgb_col[b*6 +: 6] = {rgb_bits(i_outbuf_out_data[b*DATA_WIDTH +: DATA_WIDTH], r_plane),
                                   rgb_bits(r_upper[b*DATA_WIDTH +: DATA_WIDTH], r_plane)};
        end
    end

    // Scan state, counters, capture and registered panel outputs.
    always_ff @(posedge i_out_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_col       <= '0;
            r_cyc       <= '0;
            r_row       <= '0;
            r_plane     <= '0;
            r_upper     <= '0;
            r_addr      <= '0;
            r_rgb       <= '0;
            r_pclk      <= 1'b0;
            r_lat       <= 1'b0;
            r_panel_row <= '0;
        end else begin
            r_state <= w_state_d;
            r_col   <= w_col_d;
            r_cyc   <= w_cyc_d;
            r_row   <= w_row_d;
            r_plane <= w_plane_d;

            if (r_state == SHIFT && r_col != COL_LAST && r_cyc == CYC_UPPER) begin
                r_upper <= i_outbuf_out_data;
            end

            // The final slot issues no addresses, so ADDR keeps its last value.
            if (w_state_d == SHIFT && w_col_d != COL_LAST) begin
                if (w_cyc_d == '0) begin
                    r_addr <= w_addr_up;
                end else if (w_cyc_d == CYC_W'(1)) begin
                    r_addr <= w_addr_lo;
                end
            end

            // Lower pixel arrives in the last slot cycle and is used straight off the bus.
            if (w_state_d != SHIFT) begin
                r_rgb <= '0;
            end else if (r_state == SHIFT && r_cyc == CYC_LAST) begin
                r_rgb <= w_rgb_col;
            end

            r_pclk <= (w_state_d == SHIFT) && (w_col_d != '0) && (w_cyc_d == CYC_PCLK);
            r_lat  <= (w_state_d == LATCH);
            if (w_state_d == LATCH) begin
                r_panel_row <= r_row;
            end
        end
    end

    assign o_outbuf_out_addr = r_addr;
    assign o_panel_rgb       = r_rgb;
    assign o_panel_clk       = r_pclk;
    assign o_panel_lat       = r_lat;
    assign o_panel_oe_n      = w_oe_n;
    assign o_panel_row       = r_panel_row;
    assign o_frame_done      = (r_state == DISPLAY) && w_oe_done &&
                               (r_plane == PLANE_LAST) && (r_row == ROW_LAST);

endmodule

// File: tb/tb_outbuf_scan_reader.sv
// Self-checking bench for outbuf_scan_reader with a latency-2 RAM model per instance.
module tb_outbuf_scan_reader;

    localparam int unsigned NB = 3;
    localparam int unsigned DW = 24;
    localparam int unsigned AW = 11;
    localparam int FRAME = 37488;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ena = 1'b0;

    logic [AW-1:0]    addr0, addr1;
    logic [DW*NB-1:0] data0, data1;
    logic [6*NB-1:0]  rgb0, rgb1;
    logic pclk0, pclk1, lat0, lat1, oe0, oe1, fd0, fd1;
    logic [3:0] row0, row1;
    logic [AW-1:0] a0_d1, a0_d2, a1_d1, a1_d2;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    // Synchronous-read RAM model, two cycles address-to-data.
    always @(posedge clk) begin
        a0_d1 <= addr0;
        a0_d2 <= a0_d1;
        a1_d1 <= addr1;
        a1_d2 <= a1_d1;
    end

    function automatic logic [23:0] pix(input int unsigned a, input int unsigned b);
        logic [31:0] x;
        if (b == 1 && a == 0) return 24'hFF0000;
        if (b == 1 && a == 1024) return 24'h0000FF;
        x = a * 32'd2654435761 + b * 32'd40503 + 32'd12345;
        x = x ^ (x >> 13);
        return x[23:0];
    endfunction

    function automatic logic [DW*NB-1:0] bus_at(input logic [AW-1:0] a);
        logic [DW*NB-1:0] v;
        v = '0;
        for (int b = 0; b < NB; b++) v[b*DW +: DW] = pix(32'(a), b);
        return v;
    endfunction

    // Expected {R2,G2,B2,R1,G1,B1} per block for one column.
    function automatic logic [6*NB-1:0] exp_col(input int r, input int p, input int col);
        logic [6*NB-1:0] v;
        logic [23:0] up, lo;
        v = '0;
        for (int b = 0; b < NB; b++) begin
            up = pix(r * 64 + col, b) >> p;
            lo = pix((r + 16) * 64 + col, b) >> p;
            v[b*6+5] = lo[16];
            v[b*6+4] = lo[8];
            v[b*6+3] = lo[0];
            v[b*6+2] = up[16];
            v[b*6+1] = up[8];
            v[b*6+0] = up[0];
        end
        return v;
    endfunction

    assign data0 = bus_at(a0_d2);
    assign data1 = bus_at(a1_d2);

    outbuf_scan_reader u_dut (
        .i_out_clk         (clk),
        .i_rst_n           (rst_n),
        .i_ena             (ena),
        .o_outbuf_out_addr (addr0),
        .i_outbuf_out_data (data0),
        .o_panel_rgb       (rgb0),
        .o_panel_clk       (pclk0),
        .o_panel_lat       (lat0),
        .o_panel_oe_n      (oe0),
        .o_panel_row       (row0),
        .o_frame_done      (fd0)
    );

    outbuf_scan_reader #(
        .OE_BASE (3)
    ) u_dut_oe3 (
        .i_out_clk         (clk),
        .i_rst_n           (rst_n),
        .i_ena             (ena),
        .o_outbuf_out_addr (addr1),
        .i_outbuf_out_data (data1),
        .o_panel_rgb       (rgb1),
        .o_panel_clk       (pclk1),
        .o_panel_lat       (lat1),
        .o_panel_oe_n      (oe1),
        .o_panel_row       (row1),
        .o_frame_done      (fd1)
    );

    task automatic reset_and_start();
        @(negedge clk);
        rst_n = 1'b0;
        ena = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int first_clk;
        logic [6*NB-1:0] first_rgb;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({addr0, rgb0, pclk0, lat0, row0, fd0} !== '0) $display("FAIL por_zero: got %0h expected 0", {addr0, rgb0, pclk0, lat0, row0, fd0});
        else passed++;
        total++;
        if (oe0 !== 1'b1) $display("FAIL por_oe_n: got %b expected 1", oe0);
        else passed++;

        // Start a scan, then reset it in the middle of SHIFT.
        @(negedge clk);
        ena = 1'b1;
        rst_n = 1'b1;
        repeat (43) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (addr0 !== '0) $display("FAIL rst_addr: got %0d expected 0", addr0); else passed++;
        total++; if (rgb0 !== '0) $display("FAIL rst_rgb: got %0h expected 0", rgb0); else passed++;
        total++; if (pclk0 !== 1'b0) $display("FAIL rst_pclk: got %b expected 0", pclk0); else passed++;
        total++; if (lat0 !== 1'b0) $display("FAIL rst_lat: got %b expected 0", lat0); else passed++;
        total++; if (row0 !== '0) $display("FAIL rst_row: got %0d expected 0", row0); else passed++;
        total++; if (fd0 !== 1'b0) $display("FAIL rst_fd: got %b expected 0", fd0); else passed++;
        total++; if (oe0 !== 1'b1) $display("FAIL rst_oe_n: got %b expected 1", oe0); else passed++;

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        first_clk = -1;
        first_rgb = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                total++; if (addr0 !== 11'd0) $display("FAIL addr_up0: got %0d expected 0", addr0); else passed++;
            end
            if (k == 1) begin
                total++; if (addr0 !== 11'd1024) $display("FAIL addr_lo0: got %0d expected 1024", addr0); else passed++;
            end
            if (k == 4) begin
                total++; if (addr0 !== 11'd1) $display("FAIL addr_up1: got %0d expected 1", addr0); else passed++;
            end
            if (pclk0 && first_clk < 0) begin
                first_clk = k;
                first_rgb = rgb0;
            end
        end
        total++;
        if (first_clk != 6) $display("FAIL first_pclk_cycle: got %0d expected 6", first_clk);
        else passed++;
        total++;
        if (first_rgb[11:6] !== 6'b001100) $display("FAIL bit_map_blk1: got %b expected 001100", first_rgb[11:6]);
        else passed++;
    endtask

    task automatic test_frame();
        logic [6*NB-1:0] sb[$];
        int exp_runs[$];
        logic [6*NB-1:0] e;
        logic [3:0] prev_row;
        int r, p, plane_start, rel, plen;
        int clk_cnt, lat_cnt, lat_pos, oe_lo, oe_first, fd_cnt, fd_pos, run_len;
        bit row_bad;

        reset_and_start();
        r = 0; p = 0; plane_start = 0;
        clk_cnt = 0; lat_cnt = 0; lat_pos = -1; oe_lo = 0; oe_first = -1;
        fd_cnt = 0; fd_pos = -1; run_len = 0; row_bad = 1'b0;
        prev_row = 4'd0;
        for (int c = 0; c < 64; c++) sb.push_back(exp_col(0, 0, c));
        for (int q = 0; q < 8; q++) exp_runs.push_back(3 << q);

        for (int cyc = 0; cyc < FRAME + 262; cyc++) begin
            @(posedge clk);
            #1;
            rel = cyc - plane_start;
            if (pclk0) begin
                clk_cnt++;
                total++;
                if (sb.size() == 0) $display("FAIL rgb_sb_empty: cycle %0d got %0h expected none", cyc, rgb0);
                else begin
                    e = sb.pop_front();
                    if (rgb0 !== e) $display("FAIL rgb_col r%0d p%0d: got %0h expected %0h", r, p, rgb0, e);
                    else passed++;
                end
            end
            if (lat0) begin
                lat_cnt++;
                lat_pos = rel;
                total++;
                if (row0 !== 4'(r)) $display("FAIL row_at_lat: got %0d expected %0d", row0, r);
                else passed++;
            end
            if (row0 !== prev_row && !lat0) row_bad = 1'b1;
            prev_row = row0;
            if (!oe0) begin
                if (oe_first < 0) oe_first = rel;
                oe_lo++;
            end
            if (fd0) begin
                fd_cnt++;
                fd_pos = cyc;
            end
            if (!oe1) run_len++;
            else if (run_len > 0) begin
                if (exp_runs.size() > 0) begin
                    total++;
                    if (run_len != exp_runs[0]) $display("FAIL oe3_width: got %0d expected %0d", run_len, exp_runs[0]);
                    else passed++;
                    void'(exp_runs.pop_front());
                end
                run_len = 0;
            end

            plen = 261 + (1 << p);
            if (rel == plen - 1) begin
                total++; if (clk_cnt != 64) $display("FAIL pclk_count r%0d p%0d: got %0d expected 64", r, p, clk_cnt); else passed++;
                total++; if (lat_cnt != 1 || lat_pos != 260) $display("FAIL lat_pos r%0d p%0d: got %0d/%0d expected 1/260", r, p, lat_cnt, lat_pos); else passed++;
                total++; if (oe_lo != (1 << p)) $display("FAIL oe_width r%0d p%0d: got %0d expected %0d", r, p, oe_lo, 1 << p); else passed++;
                total++; if (oe_first != 261) $display("FAIL oe_start r%0d p%0d: got %0d expected 261", r, p, oe_first); else passed++;
                plane_start = cyc + 1;
                p++;
                if (p == 8) begin
                    p = 0;
                    r = (r == 15) ? 0 : r + 1;
                end
                clk_cnt = 0; lat_cnt = 0; lat_pos = -1; oe_lo = 0; oe_first = -1;
                for (int c = 0; c < 64; c++) sb.push_back(exp_col(r, p, c));
            end
        end
        total++; if (fd_cnt != 1 || fd_pos != FRAME - 1) $display("FAIL frame_done: got %0d@%0d expected 1@%0d", fd_cnt, fd_pos, FRAME - 1); else passed++;
        total++; if (row_bad) $display("FAIL row_change_without_lat: got 1 expected 0"); else passed++;
        total++; if (exp_runs.size() != 0) $display("FAIL oe3_runs_left: got %0d expected 0", exp_runs.size()); else passed++;
    endtask

    task automatic test_ena_drop();
        int fd_pos, max_row, changes, lows, clks;
        bit dropped;
        logic [AW-1:0] last_addr;
        reset_and_start();
        fd_pos = -1; max_row = 0; dropped = 1'b0;
        for (int cyc = 0; cyc < FRAME + 50; cyc++) begin
            @(posedge clk);
            #1;
            if (int'(row0) > max_row) max_row = int'(row0);
            if (!dropped && row0 == 4'd5) begin
                ena = 1'b0;
                dropped = 1'b1;
            end
            if (fd0) begin
                fd_pos = cyc;
                break;
            end
        end
        total++; if (!dropped) $display("FAIL ena_drop_row5: got 0 expected 1"); else passed++;
        total++; if (fd_pos != FRAME - 1) $display("FAIL ena_drop_fd: got %0d expected %0d", fd_pos, FRAME - 1); else passed++;
        total++; if (max_row != 15) $display("FAIL ena_drop_rows: got %0d expected 15", max_row); else passed++;

        changes = 0; lows = 0; clks = 0;
        @(posedge clk);
        #1;
        last_addr = addr0;
        total++; if (addr0 !== 11'd2047) $display("FAIL idle_addr: got %0d expected 2047", addr0); else passed++;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (addr0 !== last_addr) changes++;
            if (!oe0) lows++;
            if (pclk0) clks++;
        end
        total++; if (changes != 0) $display("FAIL idle_addr_changes: got %0d expected 0", changes); else passed++;
        total++; if (lows != 0) $display("FAIL idle_oe_low: got %0d expected 0", lows); else passed++;
        total++; if (clks != 0) $display("FAIL idle_pclk: got %0d expected 0", clks); else passed++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_ena_drop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
